uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmit stage of the UART, sitting directly downstream of `baud_sel_gen`. It accepts a parallel byte over a valid/ready handshake, drives `enable_baud` to start the baud generator, and shifts out one framed character (start, data LSB-first, optional parity, stop) on `tx`. It advances exactly one bit per `baud` pulse.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame; legal values are 5 to 8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- baud  in  1  single-cycle tick from `baud_sel_gen`, one per bit period while `enable_baud`=1.
- tx_data  in  DATA_BITS  character to send.
- tx_valid  in  1  `tx_data` is valid.
- tx_ready  out  1  block can accept a character (high only in IDLE).
- enable_baud  out  1  run request to `baud_sel_gen`; its counter restarts from zero on each rise.
- tx_busy  out  1  frame in progress; upstream must hold `baud_sel` stable while high.
- tx  out  1  serial line; idles high.

## Operation
- FSM states:
  - IDLE: tx=1, enable_baud=0, tx_ready=1.
  - START: tx=0.
  - DATA: tx = shift register bit 0.
  - PARITY: tx = parity bit.
  - STOP: tx=1.
- Accept condition: tx_valid & tx_ready at a clock edge.
  - tx_data is latched into the shift register.
  - Parity is computed as the XOR of the data bits, inverted when PARITY_ODD=1.
  - Bit counter is cleared; next state is START.
- Transitions, each taken only on a cycle with baud=1:
  - START → DATA.
  - DATA: shift right and increment the counter. When counter = DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY → STOP.
  - STOP: if STOP_BITS=2 and this is the first stop tick, stay; otherwise go to IDLE.
- baud is ignored in IDLE. Ticks are not counted on the accept cycle.
- tx, enable_baud and tx_busy are registered outputs. tx_ready = (state == IDLE).
- tx_busy = enable_baud = (state != IDLE).
- Bit counter width is $clog2(DATA_BITS). The counter does not wrap within a frame.

## Timing
- Reset values, asserted asynchronously and held while rst=1: tx=1, enable_baud=0, tx_busy=0, tx_ready=1, state IDLE, shift register 0.
- Accept at edge N: from cycle N+1, tx=0 and enable_baud=1. The start bit lasts until the first baud tick, one full bit period later.
- Each bit changes in the cycle after the baud tick that ends the previous bit.
- Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS ticks.
- After the final stop tick at edge M: IDLE from M+1, so tx_ready=1 and enable_baud=0.
- Earliest next accept is edge M+1, so frames are back-to-back with no line gap beyond one clock.
- Reset mid-frame: tx returns to 1 and enable_baud to 0 immediately. The partial frame is discarded and not retried.
- Changes to tx_valid or tx_data while busy have no effect.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the PARITY_EVEN/PARITY_ODD constants;
  - the baud_sel encodings (00=9600, 01=19200, 10=38400, 11=57600), also used by `baud_sel_gen` and the future receiver.
- Single module with no sub-module. Shift register, counter and FSM together stay within about 150 lines.

## Test plan
All scenarios use a synthetic `baud` pulse every 16 clocks while enable_baud=1, plus one integration run with the real `baud_sel_gen` at baud_sel=11.
- Reset: assert rst mid-simulation → tx=1, tx_ready=1, enable_baud=0, tx_busy=0 in the same cycle.
- 8N1 send 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1. tx_ready rises one cycle after the 10th tick.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 → parity bit 1, 11 ticks. With PARITY_ODD=1 → parity bit 0.
- Back-to-back: tx_valid held high with 0xA5 then 0x3C → second accepted at the first edge after the first frame's last stop tick. tx stays 1 for exactly one clock between frames.
- Reset after the 4th tick of 0xC3, then send 0xFF → line returns high immediately. The next frame is the full 10 bits 0,1×8,1 with no residue.
- Stray baud pulses in IDLE plus STOP_BITS=2 → no state change while idle. A two-stop frame takes 11 ticks with tx high for the last two.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

   // Transmit FSM states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Parity sense selection
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // baud_sel encodings shared with baud_sel_gen and the receiver
   localparam logic [1:0] BAUD_9600  = 2'b00;
   localparam logic [1:0] BAUD_19200 = 2'b01;
   localparam logic [1:0] BAUD_38400 = 2'b10;
   localparam logic [1:0] BAUD_57600 = 2'b11;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter, one bit per baud tick
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 enable_baud,
   output logic                 tx_busy,
   output logic                 tx
);
   import uart_pkg::*;

   localparam int CW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
   localparam logic PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;

   tx_state_t            state, state_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 parity, parity_n;
   logic                 stop_second, stop_second_n;
   logic                 tx_n;

   assign tx_ready = (state == IDLE);

   // State, datapath and registered line outputs; reset forces the line idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shift       <= '0;
         cnt         <= '0;
         parity      <= 1'b0;
         stop_second <= 1'b0;
         tx          <= 1'b1;
         enable_baud <= 1'b0;
         tx_busy     <= 1'b0;
      end else begin
         state       <= state_n;
         shift       <= shift_n;
         cnt         <= cnt_n;
         parity      <= parity_n;
         stop_second <= stop_second_n;
         tx          <= tx_n;
         enable_baud <= (state_n != IDLE);
         tx_busy     <= (state_n != IDLE);
      end
   end

   // Next-state logic; every move out of a frame state waits for a baud tick
   always_comb begin
      state_n       = state;
      shift_n       = shift;
      cnt_n         = cnt;
      parity_n      = parity;
      stop_second_n = stop_second;
      case (state)
         IDLE: begin
            if (tx_valid) begin
               shift_n       = tx_data;
               parity_n      = (^tx_data) ^ PAR_SENSE;
               cnt_n         = '0;
               stop_second_n = 1'b0;
               state_n       = START;
            end
         end
         START: begin
            if (baud) state_n = DATA;
         end
         DATA: begin
            if (baud) begin
               shift_n = shift >> 1;
               if (cnt == LAST_BIT) begin
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (baud) state_n = STOP;
         end
         STOP: begin
            if (baud) begin
               if (STOP_BITS == 2 && !stop_second) begin
                  stop_second_n = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level for the state being entered, so tx changes with the state register
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         PARITY:  tx_n = parity_n;
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx over four frame formats
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       stray = 1'b0;

   logic valid [4];
   logic baud  [4];
   logic en    [4];
   logic busy  [4];
   logic rdy   [4];
   logic txl   [4];

   always #5 clk = ~clk;

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2; each with its own 16-clock tick source
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dut
         localparam int PE = (g == 1 || g == 2) ? 1 : 0;
         localparam int PO = (g == 2) ? 1 : 0;
         localparam int SB = (g == 3) ? 2 : 1;
         logic [3:0] bcnt;
         always @(posedge clk) begin
            if (!en[g]) bcnt <= 4'd0;
            else        bcnt <= bcnt + 4'd1;
         end
         assign baud[g] = (en[g] && bcnt == 4'd15) || stray;
         uart_tx #(
            .DATA_BITS(8), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
         ) u_dut (
            .clk(clk), .rst(rst), .baud(baud[g]), .tx_data(data),
            .tx_valid(valid[g]), .tx_ready(rdy[g]), .enable_baud(en[g]),
            .tx_busy(busy[g]), .tx(txl[g])
         );
      end
   endgenerate

   typedef struct {
      logic b;
      logic last;
      int   len;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   tick_cnt = 0;
   int   frame_ticks = 0;
   int   sel = 0;
   logic chk_rdy = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic push_frame(input int idx, input logic [7:0] d);
      int   pe, po, sb, len;
      logic p;
      pe  = (idx == 1 || idx == 2) ? 1 : 0;
      po  = (idx == 2) ? 1 : 0;
      sb  = (idx == 3) ? 2 : 1;
      len = 1 + 8 + pe + sb;
      q.push_back('{1'b0, 1'b0, len});
      for (int i = 0; i < 8; i++) q.push_back('{d[i], 1'b0, len});
      if (pe != 0) begin
         p = (^d) ^ (po != 0);
         q.push_back('{p, 1'b0, len});
      end
      for (int s = 0; s < sb; s++) q.push_back('{1'b1, (s == sb - 1), len});
   endtask

   // Scoreboard: each tick of the selected DUT retires one expected line bit
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         frame_ticks = 0;
         chk_rdy = 1'b0;
      end else begin
         if (chk_rdy) begin
            check("ready_after_stop", int'(rdy[sel]), 1);
            check("baud_off_after_stop", int'(en[sel]), 0);
            chk_rdy = 1'b0;
         end
         if (baud[sel] && busy[sel]) begin
            tick_cnt++;
            frame_ticks++;
            if (q.size() == 0) begin
               check("unexpected_tick", 1, 0);
            end else begin
               e = q.pop_front();
               check("line_bit", int'(txl[sel]), int'(e.b));
               if (e.last) begin
                  check("frame_len", frame_ticks, e.len);
                  frame_ticks = 0;
                  chk_rdy = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_busy(input int idx, input logic level, input string tag);
      int n;
      n = 0;
      while (busy[idx] !== level && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy[idx] !== level) check(tag, 0, 1);
   endtask

   task automatic wait_idle(input int idx);
      int n;
      n = 0;
      while (!(q.size() == 0 && rdy[idx] && !chk_rdy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("timeout_idle", 0, 1);
      @(negedge clk);
   endtask

   task automatic send(input int idx, input logic [7:0] d);
      sel = idx;
      push_frame(idx, d);
      data = d;
      valid[idx] = 1'b1;
      @(negedge clk);
      wait_busy(idx, 1'b1, "accept_timeout");
      check("start_bit", int'(txl[idx]), 0);
      check("baud_enabled", int'(en[idx]), 1);
      valid[idx] = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      for (int i = 0; i < 4; i++) valid[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", int'(txl[0]), 1);
      check("rst_ready", int'(rdy[0]), 1);
      check("rst_baud", int'(en[0]), 0);
      check("rst_busy", int'(busy[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      send(0, 8'h55);
      wait_idle(0);
      send(1, 8'h07);
      wait_idle(1);
      send(2, 8'h07);
      wait_idle(2);

      sel = 0;
      push_frame(0, 8'hA5);
      push_frame(0, 8'h3C);
      data = 8'hA5;
      valid[0] = 1'b1;
      @(negedge clk);
      wait_busy(0, 1'b1, "b2b_accept1");
      data = 8'h3C;
      wait_busy(0, 1'b0, "b2b_end1");
      check("b2b_gap_tx", int'(txl[0]), 1);
      @(negedge clk);
      check("b2b_start2_tx", int'(txl[0]), 0);
      check("b2b_busy2", int'(busy[0]), 1);
      valid[0] = 1'b0;
      data = 8'h00;
      wait_idle(0);

      sel = 0;
      push_frame(0, 8'hC3);
      data = 8'hC3;
      valid[0] = 1'b1;
      @(negedge clk);
      wait_busy(0, 1'b1, "c3_accept");
      valid[0] = 1'b0;
      base = tick_cnt;
      n = 0;
      while (tick_cnt < base + 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (tick_cnt < base + 4) check("c3_tick_timeout", 0, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_tx", int'(txl[0]), 1);
      check("midrst_ready", int'(rdy[0]), 1);
      check("midrst_baud", int'(en[0]), 0);
      check("midrst_busy", int'(busy[0]), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(0, 8'hFF);
      wait_idle(0);

      sel = 3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stray = 1'b1;
         @(negedge clk);
         stray = 1'b0;
         check("stray_ready", int'(rdy[3]), 1);
         check("stray_tx", int'(txl[3]), 1);
         check("stray_busy", int'(busy[3]), 0);
      end
      @(negedge clk);
      send(3, 8'h81);
      wait_idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
